// File: rtl/glitch_injector_pkg.sv
// rtl/glitch_injector_pkg.sv - shared types and default widths for the glitch injector
package glitch_pkg;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_GAP_W = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        KIND_SET_LO = 2'b00,
        KIND_SET_HI = 2'b01,
        KIND_PULSE  = 2'b10,
        KIND_RSVD   = 2'b11
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } inj_state_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/glitch_injector_if.sv
// rtl/glitch_injector_if.sv - command handshake bundle between sequencer and injector
interface glitch_injector_if
    import glitch_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP_W = DEF_GAP_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [LEN_W-1:0] cmd_len;
    logic [GAP_W-1:0] cmd_gap;

    modport master (
        output cmd_valid, cmd_kind, cmd_len, cmd_gap,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_len, cmd_gap,
        output cmd_ready
    );
endinterface

// File: rtl/glitch_injector_pulse_timer.sv
// rtl/glitch_injector_pulse_timer.sv - loadable down-counter timing pulse and gap phases
module pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);
endmodule

// File: rtl/glitch_injector.sv
// rtl/glitch_injector.sv - drives a base level and emits cycle-exact opposite-polarity pulses with guard gaps
module glitch_injector
    import glitch_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP_W = DEF_GAP_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    glitch_injector_if.slave     cmd,
    output logic                 sig_out,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err,
    output logic [CNT_W-1:0]     pulse_cnt
);
    localparam int TW = max_w(LEN_W, GAP_W);

    inj_state_e       r_state, w_next_state;
    logic             r_base, w_base_next;
    logic             r_sig, w_sig_next;
    logic             r_done, w_done_next;
    logic             r_err, w_err_next;
    logic [GAP_W-1:0] r_gap;
    logic             w_gap_load;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_inc;
    logic             w_load, w_dec, w_zero;
    logic [TW-1:0]    w_load_val;
    logic [TW-1:0]    w_len_m1, w_gap_m1;
    logic             w_accept;

    assign cmd.cmd_ready = (r_state == ST_IDLE) && reset_n;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

    // A zero length is stretched to one full cycle so the pulse is never lost.
    assign w_len_m1 = (cmd.cmd_len == '0) ? '0 : TW'(cmd.cmd_len) - TW'(1);
    assign w_gap_m1 = TW'(r_gap) - TW'(1);

    pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_base_next  = r_base;
        w_sig_next   = r_sig;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_gap_load   = 1'b0;
        w_cnt_inc    = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_dec        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_kind_e'(cmd.cmd_kind))
                        KIND_SET_LO: begin
                            w_base_next = 1'b0;
                            w_sig_next  = 1'b0;
                        end
                        KIND_SET_HI: begin
                            w_base_next = 1'b1;
                            w_sig_next  = 1'b1;
                        end
                        KIND_PULSE: begin
                            w_sig_next   = ~r_base;
                            w_load       = 1'b1;
                            w_load_val   = w_len_m1;
                            w_gap_load   = 1'b1;
                            w_next_state = ST_PULSE;
                        end
                        default: w_err_next = 1'b1;
                    endcase
                end
            end
            ST_PULSE: begin
                if (w_zero) begin
                    w_sig_next = r_base;
                    if (r_gap == '0) begin
                        w_next_state = ST_IDLE;
                        w_done_next  = 1'b1;
                        w_cnt_inc    = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_load_val   = w_gap_m1;
                        w_next_state = ST_GAP;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                    w_cnt_inc    = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_base  <= 1'b0;
            r_sig   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_gap   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_base  <= w_base_next;
            r_sig   <= w_sig_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            if (w_gap_load) begin
                r_gap <= cmd.cmd_gap;
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sig_out   = r_sig;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign cmd_err   = r_err;
    assign pulse_cnt = r_cnt;
endmodule

// File: tb/tb_glitch_injector.sv
// tb/tb_glitch_injector.sv - scoreboard bench for glitch_injector with a command-level reference model
module tb_glitch_injector;
    import glitch_pkg::*;

    localparam int LW = 8;
    localparam int GW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    glitch_injector_if #(.LEN_W(LW), .GAP_W(GW)) cif ();

    logic          sig_out, busy, done, cmd_err;
    logic [CW-1:0] pulse_cnt;

    glitch_injector #(.LEN_W(LW), .GAP_W(GW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (cif.slave),
        .sig_out   (sig_out),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err),
        .pulse_cnt (pulse_cnt)
    );

    typedef struct {
        bit is_err;
        int width;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_base   = 0;
    int   m_cnt    = 0;
    int   last_acc = 0;
    int   last_occ = 0;
    bit   b2b      = 1'b0;
    int   width    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int kind, input int len, input int gap);
        exp_t e;
        bit   got = 1'b0;
        int   acc, occ, l;
        cif.cmd_valid = 1'b1;
        cif.cmd_kind  = kind[1:0];
        cif.cmd_len   = len[LW-1:0];
        cif.cmd_gap   = gap[GW-1:0];
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (cif.cmd_ready) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            cif.cmd_valid = 1'b0;
            b2b = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cif.cmd_valid = 1'b0;
        cif.cmd_kind  = 2'($urandom);
        cif.cmd_len   = LW'($urandom);
        cif.cmd_gap   = GW'($urandom);
        if (b2b) check("accept_spacing", acc - last_acc, last_occ);
        occ = 1;
        case (kind)
            0: m_base = 0;
            1: m_base = 1;
            2: begin
                l = (len == 0) ? 1 : len;
                m_cnt = (m_cnt + 1) % (1 << CW);
                e.is_err = 1'b0; e.width = l; e.cnt = m_cnt; e.cyc = acc + l + gap;
                sb_q.push_back(e);
                occ = l + gap + 1;
            end
            default: begin
                e.is_err = 1'b1; e.width = 0; e.cnt = m_cnt; e.cyc = acc;
                sb_q.push_back(e);
            end
        endcase
        last_acc = acc;
        last_occ = occ;
        b2b = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        b2b = 1'b0;
    endtask

    // Monitor: per-cycle idle level, pulse width tracking, and done/err strobes against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            width = 0;
        end else begin
            if (sig_out != m_base[0]) width++;
            if (!busy) check("idle_level", int'(sig_out), m_base);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_kind", int'(e.is_err), 0);
                    check("pulse_width", width, e.width);
                    check("done_cycle", cyc, e.cyc);
                    check("done_pulse_cnt", int'(pulse_cnt), e.cnt);
                    check("done_busy", int'(busy), 0);
                end
                width = 0;
            end
            if (cmd_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_err", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("err_kind", int'(e.is_err), 1);
                    check("err_cycle", cyc, e.cyc);
                    check("err_pulse_cnt", int'(pulse_cnt), e.cnt);
                    check("err_busy", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int k, len, gap;
        cif.cmd_valid = 1'b0;
        cif.cmd_kind  = 2'b00;
        cif.cmd_len   = '0;
        cif.cmd_gap   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sig_out", int'(sig_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        check("rst_pulse_cnt", int'(pulse_cnt), 0);
        check("rst_cmd_ready", int'(cif.cmd_ready), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        issue(1, 0, 0);
        idle(1);
        check("set_hi_sig", int'(sig_out), 1);
        check("set_hi_busy", int'(busy), 0);
        check("set_hi_cnt", int'(pulse_cnt), 0);

        issue(0, 0, 0);
        issue(2, 3, 2);
        issue(1, 0, 0);
        issue(2, 0, 0);
        issue(2, 0, 0);
        issue(3, 5, 5);
        issue(2, 1, 1);
        idle(3);

        issue(2, 10, 0);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_sig", int'(sig_out), 0);
        check("rst_mid_cnt", int'(pulse_cnt), 0);
        check("rst_mid_ready", int'(cif.cmd_ready), 0);
        sb_q.delete();
        m_base = 0;
        m_cnt  = 0;
        b2b    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(15);
        check("post_rst_cnt", int'(pulse_cnt), 0);

        for (int i = 0; i < 17; i++) issue(2, 1, 0);
        idle(2);
        check("wrap_cnt", int'(pulse_cnt), 1);

        repeat (60) begin
            k   = $urandom_range(0, 3);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
            issue(k, len, gap);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        for (int i = 0; i < 600 && sb_q.size() != 0; i++) @(posedge clk);
        idle(2);
        check("drain_empty", sb_q.size(), 0);
        check("final_cnt", int'(pulse_cnt), m_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/glitch_injector.md
# glitch_injector

Synthesizable stimulus source for the glitch-detection environment. It drives a single-bit output `sig_out`, which holds a programmable base level. On command it emits clean, cycle-exact pulses of the opposite polarity. Each pulse is followed by a guard gap, so a downstream glitch checker can be exercised with known short-pulse events. Commands arrive over a valid/ready handshake from a sequencer or a CPU-side register block.

## Interface

Parameters:
- `LEN_W`, default 8: width of the pulse-length field.
- `GAP_W`, default 8: width of the guard-gap field.
- `CNT_W`, default 16: width of the emitted-pulse counter.

Ports:
- `clk`, input, 1 bit: single clock; all logic is on its rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `cmd_valid`, input, 1 bit: a command is present.
- `cmd_ready`, output, 1 bit: the block can accept a command.
- `cmd_kind`, input, 2 bits: 00 SET_LO, 01 SET_HI, 10 PULSE, 11 reserved.
- `cmd_len`, input, LEN_W bits: pulse width in cycles (PULSE only).
- `cmd_gap`, input, GAP_W bits: guard cycles after the pulse (PULSE only).
- `sig_out`, output, 1 bit: registered injected signal.
- `busy`, output, 1 bit: high whenever the state is not IDLE.
- `done`, output, 1 bit: one-cycle strobe when a PULSE sequence completes.
- `cmd_err`, output, 1 bit: one-cycle strobe when a reserved kind is accepted.
- `pulse_cnt`, output, CNT_W bits: number of completed pulses; wraps at 2^CNT_W.

## Operation

- **Handshake**
  - A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = (state == IDLE) && reset_n`.
  - All `cmd_*` fields are sampled only at acceptance.
- **State machine:** IDLE, PULSE, GAP.
- **IDLE**
  - SET_LO / SET_HI: `base` ← 0 / 1; `sig_out` follows the next cycle; the state stays IDLE.
  - PULSE: `sig_out` ← `~base`; timer ← max(`cmd_len`, 1) − 1; gap register ← `cmd_gap`; go to PULSE.
  - Reserved kind (11): no state change; `cmd_err` pulses for one cycle.
- **PULSE**
  - If timer == 0: `sig_out` ← `base`. Then:
    - if gap == 0: go to IDLE, raise `done`, increment `pulse_cnt`;
    - otherwise: timer ← gap − 1 and go to GAP.
  - Otherwise: decrement the timer.
- **GAP**
  - If timer == 0: go to IDLE, raise `done`, increment `pulse_cnt`.
  - Otherwise: decrement the timer.
- **Rules**
  - `base` changes only through SET_LO / SET_HI, and only in IDLE. A SET never interrupts a pulse, because `cmd_ready` is low.
  - `cmd_len` = 0 behaves exactly like `cmd_len` = 1. The minimum pulse is one full clock period.
  - `pulse_cnt` wraps from 2^CNT_W − 1 to 0 with no flag.
  - `done` and `cmd_ready` rising occur together. A new command presented in that same cycle is accepted on the next edge.

## Timing

- **Reset values** (asynchronous, while `reset_n` is 0):
  - state = IDLE; `base` = 0;
  - `sig_out` = 0, `busy` = 0, `done` = 0, `cmd_err` = 0, `pulse_cnt` = 0, `cmd_ready` = 0.
- **Reset mid-operation:** any pulse or gap is aborted immediately and `sig_out` drops to 0. No `done` strobe and no counter increment occur for the aborted pulse.
- **Acceptance at edge T:**
  - `sig_out` changes after edge T.
  - The pulse occupies exactly L = max(len, 1) cycles, from T+1 through T+L.
  - `sig_out` returns to `base` after edge T+L.
- **Gap G > 0:** `busy` stays high for G further cycles. `done` is high in cycle T+L+G, and `cmd_ready` is high from that same cycle.
- **Gap G = 0:** `done` and `cmd_ready` are high in cycle T+L. The minimum command-to-command spacing is L+1 edges.
- **SET_LO / SET_HI:** latency is 1 cycle. Back-to-back SETs are accepted on consecutive edges.
- **Outputs:** `sig_out`, `done` and `cmd_err` are registered. `busy` and `cmd_ready` decode the state register.

## Structure

- Package `glitch_pkg` holds:
  - enum `cmd_kind_e` (SET_LO, SET_HI, PULSE, RSVD);
  - enum `inj_state_e` (IDLE, PULSE, GAP);
  - default-width localparams.
- One sub-module: `pulse_timer`, a loadable down-counter with `load`, `load_val`, `dec` and `zero` outputs, sized max(LEN_W, GAP_W). The top-level block holds the FSM, `base`, the gap register and `pulse_cnt`.

## Test plan

- **Reset and SET_HI:** reset, release, issue SET_HI → `sig_out` is 1 one cycle after acceptance; `busy` stays 0; `pulse_cnt` stays 0.
- **Basic pulse from base 0:** PULSE len=3 gap=2 → `sig_out` is 1 for exactly 3 cycles; `cmd_ready` is low for 5 cycles; one `done`; `pulse_cnt` = 1.
- **Minimum pulse, inverted base:** PULSE len=0 gap=0 with base 1 → a single-cycle low pulse; `done` in the pulse cycle; a second PULSE held valid is accepted on the next edge.
- **Reserved kind:** kind=11 → `cmd_err` for one cycle; `sig_out`, state and `pulse_cnt` unchanged.
- **Reset mid-pulse:** assert `reset_n` low during a len=10 pulse → `sig_out` goes to 0 asynchronously; `pulse_cnt` = 0; no `done` after release.
- **Counter wrap and sustained traffic:** with CNT_W=4, 17 PULSE len=1 gap=0 commands → `pulse_cnt` reads 1; every pulse exactly 1 cycle wide.
